// File: rtl/acc_mmu_arbiter.sv
// Round-robin arbiter sharing the single accelerator MMU translation port
// between several requesters, one translation outstanding at a time.

package acc_mmu_pkg;
    localparam int unsigned XLEN = 64;
    localparam int unsigned VLEN = 64;
    localparam int unsigned PLEN = 56;

    typedef struct packed {
        logic [XLEN-1:0] cause;
        logic [XLEN-1:0] tval;
        logic            valid;
    } exception_t;

    typedef struct packed {
        logic            acc_mmu_misaligned_ex;
        logic            acc_mmu_req;
        logic [VLEN-1:0] acc_mmu_vaddr;
        logic            acc_mmu_is_store;
    } acc_mmu_req_t;

    typedef struct packed {
        logic            acc_mmu_dtlb_hit;
        logic            acc_mmu_valid;
        logic [PLEN-1:0] acc_mmu_paddr;
        exception_t      acc_mmu_exception;
    } acc_mmu_resp_t;
endpackage

module acc_mmu_arbiter
    import acc_mmu_pkg::*;
#(
    parameter int unsigned NumReq = 2,
    parameter int unsigned IdxW   = $clog2(NumReq)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic [NumReq-1:0]            req_valid_i,
    output logic [NumReq-1:0]            req_ready_o,
    input  logic [NumReq-1:0][VLEN-1:0]  req_vaddr_i,
    input  logic [NumReq-1:0]            req_is_store_i,
    input  logic [NumReq-1:0]            req_misaligned_ex_i,
    output logic [NumReq-1:0]            resp_valid_o,
    output logic [PLEN-1:0]              resp_paddr_o,
    output exception_t                   resp_exception_o,
    output logic                         resp_dtlb_hit_o,
    output acc_mmu_req_t                 mmu_req_o,
    input  acc_mmu_resp_t                mmu_resp_i
);

    if (NumReq < 2 || NumReq > 8) begin : g_bad_numreq
        $error("acc_mmu_arbiter: NumReq must be within 2..8");
    end

    typedef enum logic [1:0] {IDLE, XLATE, RESP} state_t;

    state_t            state;
    logic [IdxW-1:0]   last_owner;
    logic [IdxW-1:0]   owner;
    logic              drop;
    logic [NumReq-1:0] resp_sel;

    logic              grant_any;
    logic [IdxW-1:0]   grant_idx;
    logic [IdxW-1:0]   cand;

    // Walk the ring starting after the last owner; wraps explicitly so
    // non-power-of-two NumReq never produces an out-of-range index.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = last_owner;
        for (int k = 0; k < NumReq; k++) begin
            cand = (32'(cand) == NumReq - 1) ? '0 : cand + 1'b1;
            if (!grant_any && req_valid_i[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (state == IDLE && grant_any) req_ready_o[grant_idx] = 1'b1;
    end

    // A flush arriving in the response cycle itself still suppresses delivery.
    assign resp_valid_o = (state == RESP && !flush_i) ? resp_sel : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= IDLE;
            last_owner       <= IdxW'(NumReq - 1);
            owner            <= '0;
            drop             <= 1'b0;
            resp_sel         <= '0;
            mmu_req_o        <= '0;
            resp_paddr_o     <= '0;
            resp_exception_o <= '0;
            resp_dtlb_hit_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner      <= grant_idx;
                        last_owner <= grant_idx;
                        drop       <= 1'b0;
                        mmu_req_o  <= '{acc_mmu_misaligned_ex: req_misaligned_ex_i[grant_idx],
                                        acc_mmu_req:           1'b1,
                                        acc_mmu_vaddr:         req_vaddr_i[grant_idx],
                                        acc_mmu_is_store:      req_is_store_i[grant_idx]};
                        state      <= XLATE;
                    end
                end
                XLATE: begin
                    // A page walk cannot be abandoned: keep requesting, just forget the result.
                    if (flush_i) drop <= 1'b1;
                    if (mmu_resp_i.acc_mmu_valid) begin
                        resp_paddr_o     <= mmu_resp_i.acc_mmu_paddr;
                        resp_exception_o <= mmu_resp_i.acc_mmu_exception;
                        resp_dtlb_hit_o  <= mmu_resp_i.acc_mmu_dtlb_hit;
                        resp_sel         <= (drop || flush_i) ? '0 : NumReq'(1) << owner;
                        mmu_req_o        <= '0;
                        state            <= RESP;
                    end
                end
                RESP: begin
                    resp_sel <= '0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_mmu_arbiter.sv
// Randomized bench for acc_mmu_arbiter against a transaction-level model
// that follows the grant / walk / response timing rules.

module tb_acc_mmu_arbiter;
    import acc_mmu_pkg::*;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst, flush;
    logic [N-1:0]           req_valid, req_ready, req_is_store, req_mis, resp_valid;
    logic [N-1:0][VLEN-1:0] req_vaddr;
    logic [PLEN-1:0]        resp_paddr;
    exception_t             resp_exc;
    logic                   resp_hit;
    acc_mmu_req_t           mmu_req;
    acc_mmu_resp_t          mmu_resp;

    acc_mmu_arbiter #(.NumReq(N)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .flush_i             (flush),
        .req_valid_i         (req_valid),
        .req_ready_o         (req_ready),
        .req_vaddr_i         (req_vaddr),
        .req_is_store_i      (req_is_store),
        .req_misaligned_ex_i (req_mis),
        .resp_valid_o        (resp_valid),
        .resp_paddr_o        (resp_paddr),
        .resp_exception_o    (resp_exc),
        .resp_dtlb_hit_o     (resp_hit),
        .mmu_req_o           (mmu_req),
        .mmu_resp_i          (mmu_resp)
    );

    int errs = 0, checks = 0, cyc = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // stimulus knobs
    int p_req, lat_lo, lat_hi, p_flush, p_fault, p_spur, p_rst;
    logic [N-1:0] en;

    // model: one transaction record plus the held result registers
    int           last_g;
    bit           busy, rsp_due, rsp_deliver, cur_drop;
    int           cur, rsp_own, wait_left;
    logic [VLEN-1:0] cur_va;
    bit           cur_st, cur_mis;
    logic [PLEN-1:0] h_pa;
    exception_t   h_ex;
    bit           h_hit;
    logic [N-1:0] pend;
    int           n_grant, n_deliver, n_drop;

    task automatic model_reset();
        last_g = N - 1;
        busy = 0; rsp_due = 0; cur_drop = 0;
        h_pa = '0; h_ex = '0; h_hit = 0;
        pend = '0; req_valid = '0;
    endtask

    task automatic cfg(input logic [N-1:0] e, input int pr, input int llo, input int lhi,
                       input int pf, input int pfa, input int ps, input int prs);
        en = e; p_req = pr; lat_lo = llo; lat_hi = lhi;
        p_flush = pf; p_fault = pfa; p_spur = ps; p_rst = prs;
    endtask

    task automatic run(input int ncyc);
        logic [N-1:0] exp_rdy, exp_rv;
        acc_mmu_req_t exp_mr;
        int g;
        bit fault;
        for (int n = 0; n < ncyc; n++) begin
            cyc++;
            for (int i = 0; i < N; i++) begin
                if (pend[i] && $urandom_range(99) < 3) pend[i] = 1'b0;
                else if (!pend[i] && en[i] && $urandom_range(99) < p_req) begin
                    pend[i]         = 1'b1;
                    req_vaddr[i]    = {$urandom, $urandom};
                    req_is_store[i] = 1'($urandom);
                    req_mis[i]      = 1'($urandom);
                end
            end
            req_valid = pend;
            flush     = ($urandom_range(99) < p_flush);

            fault = ($urandom_range(99) < p_fault);
            mmu_resp = '0;
            mmu_resp.acc_mmu_paddr           = PLEN'({$urandom, $urandom});
            mmu_resp.acc_mmu_dtlb_hit        = 1'($urandom);
            mmu_resp.acc_mmu_exception.valid = fault;
            mmu_resp.acc_mmu_exception.cause = fault ? 64'd13 : 64'd0;
            mmu_resp.acc_mmu_exception.tval  = fault ? cur_va : 64'd0;
            if (busy) mmu_resp.acc_mmu_valid = (wait_left == 0);
            else      mmu_resp.acc_mmu_valid = ($urandom_range(99) < p_spur);

            if (busy && $urandom_range(99) < p_rst) begin
                rst = 1'b1;
                model_reset();
                @(posedge clk); #1;
                rst = 1'b0;
                continue;
            end

            #1;
            exp_rdy = '0; exp_rv = '0; exp_mr = '0; g = -1;
            if (rsp_due) begin
                if (rsp_deliver && !flush) exp_rv[rsp_own] = 1'b1;
            end else if (busy) begin
                exp_mr.acc_mmu_req           = 1'b1;
                exp_mr.acc_mmu_vaddr         = cur_va;
                exp_mr.acc_mmu_is_store      = cur_st;
                exp_mr.acc_mmu_misaligned_ex = cur_mis;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    int c;
                    c = (last_g + k) % N;
                    if (g < 0 && req_valid[c]) g = c;
                end
                if (g >= 0) exp_rdy[g] = 1'b1;
            end
            chk("req_ready",  256'(req_ready),  256'(exp_rdy));
            chk("resp_valid", 256'(resp_valid), 256'(exp_rv));
            chk("mmu_req",    256'(mmu_req),    256'(exp_mr));
            chk("resp_paddr", 256'(resp_paddr), 256'(h_pa));
            chk("resp_exc",   256'(resp_exc),   256'(h_ex));
            chk("resp_hit",   256'(resp_hit),   256'(h_hit));

            if (rsp_due) begin
                rsp_due = 0;
                if (rsp_deliver && !flush) n_deliver++; else n_drop++;
            end else if (busy) begin
                if (flush) cur_drop = 1;
                if (wait_left == 0) begin
                    busy = 0; rsp_due = 1;
                    rsp_deliver = !cur_drop;
                    rsp_own = cur;
                    h_pa  = mmu_resp.acc_mmu_paddr;
                    h_ex  = mmu_resp.acc_mmu_exception;
                    h_hit = mmu_resp.acc_mmu_dtlb_hit;
                end else wait_left--;
            end else if (g >= 0) begin
                busy = 1; cur = g; cur_drop = 0;
                cur_va = req_vaddr[g]; cur_st = req_is_store[g]; cur_mis = req_mis[g];
                wait_left = $urandom_range(lat_hi, lat_lo);
                last_g = g; pend[g] = 1'b0;
                n_grant++;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; req_valid = '0; req_vaddr = '0;
        req_is_store = '0; req_mis = '0; mmu_resp = '0;
        n_grant = 0; n_deliver = 0; n_drop = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // idle after reset: outputs at reset values, spurious MMU valid ignored
        cfg('0, 0, 0, 0, 20, 0, 30, 0);                     run(5);
        // single requester, one-cycle MMU answer
        cfg(N'(1), 40, 0, 0, 0, 0, 0, 0);                   run(30);
        // full contention, zero latency: strict rotation 0,1,2,...
        cfg('1, 100, 0, 0, 0, 0, 0, 0);                     run(60);
        chk("grants_seen", 256'(n_grant > 20), 256'(1));
        // long walks
        cfg('1, 100, 20, 20, 0, 0, 20, 0);                  run(120);
        // flush during walks
        cfg('1, 80, 5, 12, 25, 0, 10, 0);                   run(200);
        chk("drops_seen", 256'(n_drop > 0), 256'(1));
        // page faults
        cfg('1, 70, 0, 3, 0, 50, 10, 0);                    run(150);
        // reset while translating
        cfg('1, 70, 2, 8, 5, 20, 10, 8);                    run(250);
        // mixed
        cfg('1, 50, 0, 6, 10, 20, 15, 1);                   run(800);
        chk("delivers_seen", 256'(n_deliver > 50), 256'(1));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/acc_mmu_arbiter.md
# acc_mmu_arbiter

Shares CVA6's single accelerator MMU translation port between several accelerator-side requesters, such as the vector load and store units. The block sits between those requesters and the `acc_mmu_req` / `acc_mmu_resp` fields of the accelerator interface. It accepts one translation at a time using round-robin arbitration. It holds the request stable toward the MMU until `acc_mmu_valid`, then returns the registered result to the owning requester. Only one translation is outstanding at any time.

## Interface
- `NumReq`, default 2: number of requesters; legal range 2..8.
- `IdxW`, default `$clog2(NumReq)`: width of the owner index; derived, not overridden.

Ports:
- `clk_i`  in  1  clock.
- `rst_i`  in  1  reset; one clock, synchronous, active-high.
- `flush_i`  in  1  pipeline flush; the current translation's result is discarded.
- `req_valid_i`  in  NumReq  per-requester translation request.
- `req_ready_o`  out  NumReq  one-hot pulse; the request is accepted this cycle.
- `req_vaddr_i`  in  NumReq x riscv::VLEN  virtual address.
- `req_is_store_i`  in  NumReq  1 = store translation.
- `req_misaligned_ex_i`  in  NumReq  misaligned flag, forwarded to the MMU.
- `resp_valid_o`  out  NumReq  one-hot, one-cycle result pulse.
- `resp_paddr_o`  out  riscv::PLEN  physical address; shared by all requesters.
- `resp_exception_o`  out  exception_t  translation exception; shared.
- `resp_dtlb_hit_o`  out  1  DTLB hit flag; shared.
- `mmu_req_o`  out  acc_mmu_req_t  request to the CVA6 accelerator MMU port.
- `mmu_resp_i`  in  acc_mmu_resp_t  response from the CVA6 accelerator MMU port.

## Operation
- FSM states: IDLE, XLATE, RESP. Reset state is IDLE.
- IDLE:
  - If any `req_valid_i` is high, grant one requester by round-robin.
  - The search starts at `(last_owner+1) mod NumReq`.
  - Pulse `req_ready_o[g]` for the granted requester.
  - Latch `vaddr`, `is_store`, `misaligned_ex` and the owner index `g`.
  - Set `last_owner=g`, clear `drop`, go to XLATE.
- XLATE:
  - Drive `acc_mmu_req=1` and the latched fields.
  - When `acc_mmu_valid=1`:
    - register `acc_mmu_paddr`, `acc_mmu_exception` and `acc_mmu_dtlb_hit`;
    - go to RESP.
- RESP:
  - Assert `resp_valid_o[owner]=1` unless `drop` is set or `flush_i` is high.
  - Always go to IDLE.
- Flush:
  - `flush_i` in XLATE sets `drop`.
  - The request keeps being driven until `acc_mmu_valid`, because a page walk cannot be abandoned.
  - The result is then discarded.
  - `flush_i` in IDLE has no effect; a request presented in the same cycle is still granted.
- `resp_paddr_o`, `resp_exception_o` and `resp_dtlb_hit_o` are valid only while `resp_valid_o` is high. Otherwise they hold their last value.
- Requests are never accepted in XLATE or RESP. `req_ready_o` is all-zero in those states.
- NumReq is not a power of two: the round-robin wraps at NumReq-1 → 0; index values ≥ NumReq never occur.
- `last_owner` reset value is NumReq-1, so requester 0 wins the first contention.

## Timing
- Reset values:
  - `req_ready_o=0`, `resp_valid_o=0`;
  - `mmu_req_o` all-zero (`acc_mmu_req=0`);
  - `resp_paddr_o=0`, `resp_exception_o='0`, `resp_dtlb_hit_o=0`;
  - state IDLE, `drop=0`.
- Cycle sequence, with the grant in cycle T:
  - `req_ready_o` high in T;
  - `acc_mmu_req` high from T+1 through the cycle `acc_mmu_valid` is sampled high (cycle V, V ≥ T+1);
  - `resp_valid_o` high in V+1;
  - the next grant is possible at V+2.
- Minimum spacing between grants is 3 cycles, when the MMU answers in the first XLATE cycle.
- `mmu_req_o` fields stay stable for the whole XLATE state. They are zero outside XLATE.
- `acc_mmu_valid` sampled outside XLATE is ignored.
- Reset asserted mid-translation: the next cycle is IDLE with `acc_mmu_req=0` and no response. The MMU shares `rst_i` and must reset in the same cycle.
- Requesters hold `req_valid_i` and their fields until `req_ready_o`. Deasserting before grant is allowed and simply withdraws the request.

## Test plan
- Single request: req0 `vaddr=0x8000_1000`, MMU valid 1 cycle later with `paddr=0x8000_1000`, no exception → `req_ready_o=01` at T, `acc_mmu_req` in T+1, `resp_valid_o=01` at T+2 with matching paddr.
- Contention: req0 and req1 held high continuously, MMU latency 0 → grants alternate 0,1,0,1, each 3 cycles apart; responses reach the correct owner.
- Long walk: MMU valid 20 cycles after the request → `mmu_req_o` vaddr/is_store stable for all 20 cycles; exactly one `resp_valid_o` pulse; no second grant before it.
- Flush mid-walk: `flush_i` pulsed 5 cycles into XLATE → request held until valid; no `resp_valid_o`; the next pending request is granted at V+2.
- Page fault: MMU returns `acc_mmu_exception.valid=1` with a load page-fault cause → `resp_exception_o` carries that cause with `resp_valid_o` to the owner.
- Reset mid-XLATE: `rst_i` one cycle → all outputs zero the following cycle; req1 is granted first afterward only if req0 is idle.
